// File: rtl/gb_clk_gen.sv
// gb_clk_gen: programmable clock-enable generator for the gameboy core.
// NUM_CH free-running half-period dividers; one channel is selected and gated
// by a run/pause/step/burst FSM to form gb_clk_o / gb_ce_o.
// Optional feature macro: CLKGEN_CYCLE_CNT_EN adds cyc_cnt_o, a wrapping count
// of gb_ce_o pulses since reset.
module gb_clk_gen #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned SEL_W   = 1,
    parameter int unsigned BURST_W = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [1:0]              mode_i,
    input  logic                    step_i,
    input  logic [BURST_W-1:0]      burst_len_i,
    output logic [NUM_CH-1:0]       ch_clk_o,
    output logic [NUM_CH-1:0]       ch_en_o,
    output logic                    gb_clk_o,
    output logic                    gb_ce_o,
`ifdef CLKGEN_CYCLE_CNT_EN
    output logic [31:0]             cyc_cnt_o,
`endif
    output logic                    busy_o
);

    typedef enum logic [1:0] {StRun, StHold, StGrant} state_e;

    localparam logic [1:0] ModeRun   = 2'b00;
    localparam logic [1:0] ModePause = 2'b01;
    localparam logic [1:0] ModeStep  = 2'b10;

    logic [DIV_W-1:0]   cnt_q [NUM_CH];
    logic [NUM_CH-1:0]  ch_clk_q, ch_en_q, ch_wrap;
    logic [SEL_W-1:0]   sel_q, sel_clamp;
    logic [BURST_W-1:0] credit_q;
    state_e             state_q;
    logic               g_q, g_d, busy_q, step_q;
    logic               step_edge, sel_rise, sel_fall, grant;

    // Counter reaching zero marks a half-period boundary on each channel
    always_comb begin
        ch_wrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wrap[i] = (cnt_q[i] == '0);
        end
    end

    // Per-channel down-counters; a toggle to high also fires the enable pulse
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!resetn) begin
                cnt_q[i]    <= div_i[i*DIV_W +: DIV_W];
                ch_clk_q[i] <= 1'b0;
                ch_en_q[i]  <= 1'b0;
            end else if (ch_wrap[i]) begin
                cnt_q[i]    <= div_i[i*DIV_W +: DIV_W];
                ch_clk_q[i] <= ~ch_clk_q[i];
                ch_en_q[i]  <= ~ch_clk_q[i];
            end else begin
                cnt_q[i]    <= cnt_q[i] - DIV_W'(1);
                ch_en_q[i]  <= 1'b0;
            end
        end
    end

    assign sel_clamp = (32'(sel_i) < NUM_CH) ? sel_i : '0;
    assign sel_rise  = ch_wrap[sel_q] & ~ch_clk_q[sel_q];
    assign sel_fall  = ch_wrap[sel_q] & ch_clk_q[sel_q];
    assign step_edge = step_i & ~step_q;

    // Grant decision at a selected-channel rise; g holds for the whole high phase
    always_comb begin
        grant = 1'b0;
        if (mode_i == ModeRun) begin
            grant = 1'b1;
        end else if (state_q == StGrant && mode_i[1] && credit_q != '0) begin
            grant = 1'b1;
        end
        g_d = g_q;
        if (sel_rise) begin
            g_d = grant;
        end else if (sel_fall) begin
            g_d = 1'b0;
        end
    end

    // Gating FSM with credit counter, gate flag and glitch-safe select update
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StHold;
            credit_q <= '0;
            busy_q   <= 1'b0;
            g_q      <= 1'b0;
            step_q   <= 1'b0;
            sel_q    <= sel_clamp;
        end else begin
            step_q <= step_i;
            g_q    <= g_d;
            // g_q is only set while the channel is high, so gb_clk_o low means no phase is open
            if (!gb_clk_o && !sel_rise) begin
                sel_q <= sel_clamp;
            end
            unique case (mode_i)
                ModeRun: begin
                    state_q  <= StRun;
                    credit_q <= '0;
                    busy_q   <= 1'b0;
                end
                ModePause: begin
                    state_q  <= StHold;
                    credit_q <= '0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    if (state_q == StGrant) begin
                        if (sel_rise && grant) begin
                            credit_q <= credit_q - BURST_W'(1);
                        end
                        // Release only once the last granted phase has closed
                        if (credit_q == '0 && !g_d) begin
                            state_q <= StHold;
                            busy_q  <= 1'b0;
                        end
                    end else if (step_edge && mode_i == ModeStep) begin
                        credit_q <= BURST_W'(1);
                        state_q  <= StGrant;
                        busy_q   <= 1'b1;
                    end else if (step_edge && burst_len_i != '0) begin
                        credit_q <= burst_len_i;
                        state_q  <= StGrant;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= StHold;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef CLKGEN_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_q;

    // Debug count of granted gb cycles, wraps naturally
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cyc_cnt_q <= '0;
        end else if (gb_ce_o) begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
`endif

    assign ch_clk_o = ch_clk_q;
    assign ch_en_o  = ch_en_q;
    assign gb_clk_o = ch_clk_q[sel_q] & g_q;
    assign gb_ce_o  = ch_en_q[sel_q] & g_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_gb_clk_gen.sv
// Directed bench for gb_clk_gen: vector table for the free-running dividers,
// hand sequences for step, burst, pause, select switch and mid-burst reset.
module tb_gb_clk_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] div_i;
    logic [0:0]  sel_i;
    logic [1:0]  mode_i;
    logic        step_i;
    logic [15:0] burst_len_i;
    logic [1:0]  ch_clk_o, ch_en_o;
    logic        gb_clk_o, gb_ce_o, busy_o;
`ifdef CLKGEN_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_o;
`endif

    gb_clk_gen dut (
        .clk         (clk),
        .resetn      (resetn),
        .div_i       (div_i),
        .sel_i       (sel_i),
        .mode_i      (mode_i),
        .step_i      (step_i),
        .burst_len_i (burst_len_i),
        .ch_clk_o    (ch_clk_o),
        .ch_en_o     (ch_en_o),
        .gb_clk_o    (gb_clk_o),
        .gb_ce_o     (gb_ce_o),
`ifdef CLKGEN_CYCLE_CNT_EN
        .cyc_cnt_o   (cyc_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] div;
        logic [1:0]  mode;
        logic [6:0]  exp;  // {ch_clk[1:0], ch_en[1:0], gb_clk, gb_ce, busy}
    } vec_t;

    vec_t vecs [24];
    int   checks = 0;
    int   errors = 0;
    int   ce_cnt, hi_cnt, busy_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        ce_cnt   = 0;
        hi_cnt   = 0;
        busy_cnt = 0;
    endtask

    task automatic count();
        ce_cnt   += int'(gb_ce_o);
        hi_cnt   += int'(gb_clk_o);
        busy_cnt += int'(busy_o);
    endtask

    function automatic logic [6:0] outs();
        return {ch_clk_o, ch_en_o, gb_clk_o, gb_ce_o, busy_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:24] ch0_pat;
        logic [1:24] en0_pat;
        ch0_pat = 24'b000111100001111001100110;
        en0_pat = 24'b000100000001000001000100;
        // ch1 (div 0) toggles every edge: high/en after odd edges; ch0 div 3 -> 1 before edge 14
        for (int k = 1; k <= 24; k++) begin
            vecs[k-1].div  = (k < 14) ? {8'd0, 8'd3} : {8'd0, 8'd1};
            vecs[k-1].mode = 2'b00;
            vecs[k-1].exp  = {k[0], ch0_pat[k], k[0], en0_pat[k], ch0_pat[k], en0_pat[k], 1'b0};
        end

        // Divider table, run mode, sel 0
        div_i = {8'd0, 8'd3}; sel_i = 1'b0; mode_i = 2'b00; step_i = 1'b0; burst_len_i = 16'd0;
        do_reset();
        check("reset_outputs", 32'(outs()), 32'd0);
        for (int k = 0; k < 24; k++) begin
            div_i  = vecs[k].div;
            mode_i = vecs[k].mode;
            tick();
            check($sformatf("div_vec_%0d", k + 1), 32'(outs()), 32'(vecs[k].exp));
        end

        // Single step with a second step edge while busy
        div_i = {8'd0, 8'd3}; mode_i = 2'b10; step_i = 1'b0;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step_i = ((e >= 5 && e <= 6) || (e >= 9 && e <= 11));
            tick();
            count();
            if (e == 4)  check("step_ungranted_rise", 32'({ch_clk_o[0], gb_clk_o}), 32'h2);
            if (e == 5)  check("step_busy_start", 32'(busy_o), 32'd1);
            if (e == 12) check("step_grant_rise", 32'({gb_clk_o, gb_ce_o}), 32'h3);
            if (e == 15) check("step_last_high", 32'({gb_clk_o, busy_o}), 32'h3);
            if (e == 16) check("step_release", 32'({gb_clk_o, busy_o}), 32'h0);
        end
        check("step_ce_count", 32'(ce_cnt), 32'd1);
        check("step_high_count", 32'(hi_cnt), 32'd4);
        check("step_busy_count", 32'(busy_cnt), 32'd11);

        // Burst of 5
        mode_i = 2'b11; burst_len_i = 16'd5; step_i = 1'b0;
        do_reset();
        for (int e = 1; e <= 70; e++) begin
            step_i = (e >= 5);
            tick();
            count();
            if (e == 47) check("burst_last_high", 32'({gb_clk_o, busy_o}), 32'h3);
            if (e == 48) check("burst_release", 32'({gb_clk_o, busy_o}), 32'h0);
        end
        check("burst_ce_count", 32'(ce_cnt), 32'd5);
        check("burst_busy_count", 32'(busy_cnt), 32'd43);

        // Burst of 0: nothing granted, never busy
        burst_len_i = 16'd0; step_i = 1'b0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step_i = (e >= 5);
            tick();
            count();
        end
        check("burst0_ce_count", 32'(ce_cnt), 32'd0);
        check("burst0_busy_count", 32'(busy_cnt), 32'd0);

        // Run -> pause mid high phase, then switch select in pause and resume
        mode_i = 2'b00; step_i = 1'b0; sel_i = 1'b0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            mode_i = (e <= 5) ? 2'b00 : 2'b01;
            tick();
            count();
            if (e == 7) check("pause_phase_completes", 32'(gb_clk_o), 32'd1);
            if (e == 8) check("pause_phase_ends", 32'(gb_clk_o), 32'd0);
        end
        check("pause_ce_count", 32'(ce_cnt), 32'd1);
        check("pause_high_count", 32'(hi_cnt), 32'd4);
        sel_i  = 1'b1;
        hi_cnt = 0;
        for (int e = 31; e <= 40; e++) begin
            mode_i = (e >= 35) ? 2'b00 : 2'b01;
            tick();
            if (e <= 34) hi_cnt += int'(gb_clk_o);
            if (e >= 35) begin
                check($sformatf("sel1_run_%0d", e), 32'({gb_clk_o, gb_ce_o}),
                      (e % 2 == 1) ? 32'h3 : 32'h0);
            end
        end
        check("sel_switch_no_glitch", 32'(hi_cnt), 32'd0);

        // Reset on the 3rd pulse of a burst of 10
        sel_i = 1'b0; mode_i = 2'b11; burst_len_i = 16'd10; step_i = 1'b0;
        do_reset();
        for (int e = 1; e <= 28; e++) begin
            step_i = (e >= 5 && e <= 6);
            tick();
            count();
        end
        check("midburst_third_pulse", 32'({gb_ce_o, busy_o}), 32'h3);
        check("midburst_ce_count", 32'(ce_cnt), 32'd3);
`ifdef CLKGEN_CYCLE_CNT_EN
        check("cyc_cnt_before_reset", cyc_cnt_o, 32'd2);
`endif
        resetn = 1'b0;
        tick();
        check("midburst_reset_outputs", 32'(outs()), 32'd0);
`ifdef CLKGEN_CYCLE_CNT_EN
        check("cyc_cnt_after_reset", cyc_cnt_o, 32'd0);
`endif
        resetn   = 1'b1;
        ce_cnt   = 0;
        busy_cnt = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            count();
        end
        check("post_reset_ce_count", 32'(ce_cnt), 32'd0);
        check("post_reset_busy_count", 32'(busy_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_clk_gen.md
Name: gb_clk_gen

Overview:
Parametrised clock-enable generator that replaces the fixed two-counter gameboy clock divider in the top level. It produces NUM_CH independently programmable divided clocks and enable pulses, and selects one of them as the gameboy core clock. A gating FSM adds run, pause, single-step and burst modes for on-board debug. All logic is in the system clock domain. Gated outputs are glitch-free at half-period granularity.

Parameters:
NUM_CH, 2, number of divider channels (1..8)
DIV_W, 8, width of each channel's half-period reload value
SEL_W, 1, width of channel select (must satisfy 2**SEL_W >= NUM_CH)
BURST_W, 16, width of burst length

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
div_i  in  NUM_CH*DIV_W  per-channel half-period reload; channel i uses bits [i*DIV_W +: DIV_W]
sel_i  in  SEL_W  channel that drives gb_clk_o/gb_ce_o
mode_i  in  2  00 run, 01 pause, 10 single-step, 11 burst
step_i  in  1  step/burst trigger; level input, rising edge detected internally
burst_len_i  in  BURST_W  number of gb cycles per burst trigger
ch_clk_o  out  NUM_CH  free-running divided square clocks
ch_en_o  out  NUM_CH  one-clk pulse coincident with each ch_clk_o rising edge
gb_clk_o  out  1  gated clock of the selected channel
gb_ce_o  out  1  gated enable: one-clk pulse per granted gb cycle
busy_o  out  1  step/burst grant in progress

Behaviour:
- Reset (resetn low at clk edge):
  - cnt[i] <= div_i[i]
  - ch_clk_o, ch_en_o, gb_clk_o, gb_ce_o, busy_o <= 0
  - credit <= 0, step edge register <= 0
  - FSM <= HOLD; sel_q <= sel_i
- Channel i:
  - If cnt != 0: decrement.
  - If cnt == 0: reload from div_i[i] and toggle ch_clk.
  - Half-period is div+1 clk; div=0 toggles every clk.
  - New div_i values take effect only at the next reload.
  - ch_en_o[i] is registered and high for exactly the clk in which ch_clk_o[i] is first high.
- sel_q:
  - Reloads from sel_i only in a clk where gb_clk_o==0 and the currently selected channel is not about to rise.
  - sel_i values >= NUM_CH are clamped to channel 0.
- Gate flag g:
  - Evaluated only when the selected channel rises (rise = the clk where ch_en_o[sel_q] goes high); g is set at the rise if the FSM grants it.
  - g clears when ch_clk_o[sel_q] falls.
  - gb_clk_o = ch_clk_o[sel_q] & g.
  - gb_ce_o = ch_en_o[sel_q] & g.
  - Partial high phases are never emitted.
- FSM, mode sampled each clk:
  - RUN: every rise is granted. Entered when mode==00.
  - HOLD: no grants.
    - mode==01: stay in HOLD.
    - mode==10 and step edge: credit <= 1, go to GRANT.
    - mode==11 and step edge: credit <= burst_len_i, go to GRANT; if burst_len_i==0, stay in HOLD with busy_o kept 0.
  - GRANT: busy_o=1.
    - Each granted rise decrements credit.
    - When credit==0 and gb_clk_o has fallen, go to HOLD and drop busy_o.
    - Step edges in GRANT are ignored (not queued).
- Mode change:
  - Leaving RUN/GRANT for pause takes effect at the next rise; an in-progress high phase completes.
  - Changing to run from GRANT abandons the remaining credit (credit <= 0).
- Simultaneous step edge and mode change in the same clk: the new mode governs.
- Reset mid-burst: all outputs go to 0 on that edge; no residual credit.

Optional Feature:
CLKGEN_CYCLE_CNT_EN
- Defined: adds output cyc_cnt_o [31:0], counting gb_ce_o pulses since reset. It wraps 0xFFFFFFFF -> 0 and resets to 0. It drives the 7-seg debug display.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
1. NUM_CH=2, div ch0=3, mode=00, sel=0, release reset: ch_clk_o[0] rises on the 4th clk edge after release; then 4 high/4 low; ch_en_o[0] pulses every 8 clk; gb_clk_o == ch_clk_o[0].
2. div ch1=0, div ch0 changed 3->1 mid-count: ch1 toggles every clk with ch_en every 2 clk; ch0 keeps period 8 until its next reload, then period 4.
3. mode=10, one step_i rising edge: exactly one gb_ce_o pulse and one 4-clk gb_clk_o high phase. busy_o is high from the clk after the edge until gb_clk_o falls. A second step edge while busy produces nothing.
4. mode=11, burst_len=5, step edge: exactly 5 gb_ce_o pulses, then busy_o=0. With burst_len=0, a step edge gives 0 pulses and busy_o stays 0.
5. mode=00 then 01 while gb_clk_o is high: the high phase completes (4 clk); no further gb_ce_o. Switching sel 0->1 in pause takes effect with no glitch on gb_clk_o.
6. resetn low for one clk on the 3rd pulse of a burst of 10: all outputs are 0 next clk; no further gb_ce_o in HOLD. With CLKGEN_CYCLE_CNT_EN defined, cyc_cnt_o reads 0.
